axi_line_memory: RTL and testbench

- Single-port burst memory that acts as the AXI responder (slave) end of the line-fill and flush channels driven by the data and instruction caches.
- Accepts whole-line write bursts (flush) and read bursts (refill), then returns write responses and read data with a programmable read latency.
- Used as the main-memory model behind d_cache and i_cache in simulation, and as an on-chip backing RAM on FPGA builds.

---
 rtl/axi_line_memory_if.sv | 51 +++++
 rtl/axi_line_memory.sv | 152 +++++++++++++++
 tb/tb_axi_line_memory.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/axi_line_memory_if.sv
// AXI-style write/read channel bundle between a cache (master) and axi_line_memory (slave).
interface axi_line_memory_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 4
);
    logic                  awvalid;
    logic                  awready;
    logic [ID_WIDTH-1:0]   awid;
    logic [LEN_WIDTH-1:0]  awlen;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   wid;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   bid;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [LEN_WIDTH-1:0]  arlen;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;

    modport master (
        output awvalid, awid, awlen, awaddr,
        output wvalid, wid, wdata, wlast,
        output bready,
        output arvalid, arid, arlen, araddr,
        output rready,
        input  awready, wready, bvalid, bid,
        input  arready, rvalid, rid, rdata, rlast
    );

    modport slave (
        input  awvalid, awid, awlen, awaddr,
        input  wvalid, wid, wdata, wlast,
        input  bready,
        input  arvalid, arid, arlen, araddr,
        input  rready,
        output awready, wready, bvalid, bid,
        output arready, rvalid, rid, rdata, rlast
    );
endinterface

// File: rtl/axi_line_memory.sv
// Single-port burst memory acting as the AXI responder for cache line fills/flushes.
// One transaction at a time; writes take priority over reads in IDLE.
// Optional macro AXI_LINE_MEMORY_PROTOCOL_CHECK_EN builds the sticky protocol_err checker.
module axi_line_memory #(
    parameter int ADDR_WIDTH     = 26,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_WORDS_LOG2 = 12,
    parameter int READ_LATENCY   = 4,
    parameter int ID_WIDTH       = 4,
    parameter int LEN_WIDTH      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    axi_line_memory_if.slave   bus,
    output logic               protocol_err
);
    localparam int unsigned LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int unsigned LAT_LOAD = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
    localparam logic [LAT_W-1:0]          LAT_ONE = 1;
    localparam logic [MEM_WORDS_LOG2-1:0] IDX_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]      CNT_ONE = 1;

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

    state_t                    state, state_next;
    logic [DATA_WIDTH-1:0]     mem [2**MEM_WORDS_LOG2];
    logic [MEM_WORDS_LOG2-1:0] idx, idx_next;
    logic [LEN_WIDTH-1:0]      cnt, cnt_next;
    logic [LAT_W-1:0]          lat_cnt;
    logic [ID_WIDTH-1:0]       awid_q, arid_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      aw_fire, ar_fire, w_fire, r_fire, b_fire, last_beat;

    assign aw_fire   = bus.awvalid & bus.awready;
    assign ar_fire   = bus.arvalid & bus.arready;
    assign w_fire    = bus.wvalid & bus.wready;
    assign r_fire    = bus.rvalid & bus.rready;
    assign b_fire    = bus.bvalid & bus.bready;
    assign last_beat = (cnt == CNT_ONE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (aw_fire)      state_next = WR_DATA;
                else if (ar_fire) state_next = (READ_LATENCY == 0) ? RD_DATA : RD_WAIT;
            end
            RD_WAIT: if (lat_cnt == '0)          state_next = RD_DATA;
            RD_DATA: if (r_fire && last_beat)    state_next = IDLE;
            WR_DATA: if (w_fire && last_beat)    state_next = WR_RESP;
            WR_RESP: if (b_fire)                 state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // Handshake outputs; readies are held low while reset is asserted
    always_comb begin
        bus.awready = rst_n && (state == IDLE);
        bus.arready = rst_n && (state == IDLE) && !bus.awvalid;
        bus.wready  = rst_n && (state == WR_DATA);
        bus.bvalid  = (state == WR_RESP);
        bus.rvalid  = (state == RD_DATA);
        bus.rlast   = (state == RD_DATA) && last_beat;
        bus.bid     = awid_q;
        bus.rid     = arid_q;
        bus.rdata   = rdata_q;
    end

    // Word index and remaining beat count for the active burst; LEN of 0 means one beat
    always_comb begin
        idx_next = idx;
        cnt_next = cnt;
        if (aw_fire) begin
            idx_next = bus.awaddr[2 +: MEM_WORDS_LOG2];
            cnt_next = (bus.awlen == '0) ? CNT_ONE : bus.awlen;
        end else if (ar_fire) begin
            idx_next = bus.araddr[2 +: MEM_WORDS_LOG2];
            cnt_next = (bus.arlen == '0) ? CNT_ONE : bus.arlen;
        end else if (w_fire || r_fire) begin
            idx_next = idx + IDX_ONE;
            cnt_next = cnt - CNT_ONE;
        end
    end

    // Burst bookkeeping registers: index, count, ids and read-latency counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx     <= '0;
            cnt     <= '0;
            lat_cnt <= '0;
            awid_q  <= '0;
            arid_q  <= '0;
        end else begin
            idx <= idx_next;
            cnt <= cnt_next;
            if (aw_fire) awid_q <= bus.awid;
            if (ar_fire) begin
                arid_q  <= bus.arid;
                lat_cnt <= LAT_W'(LAT_LOAD);
            end else if (state == RD_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LAT_ONE;
            end
        end
    end

    // Memory array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_fire) mem[idx] <= bus.wdata;
    end

    // Registered read: fetch the word the next cycle will present, so a stalled beat holds its data
    always_ff @(posedge clk) begin
        if (!rst_n)                     rdata_q <= '0;
        else if (state_next == RD_DATA) rdata_q <= mem[idx_next];
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.awaddr[1:0], bus.awaddr[ADDR_WIDTH-1:2+MEM_WORDS_LOG2],
                                bus.araddr[1:0], bus.araddr[ADDR_WIDTH-1:2+MEM_WORDS_LOG2]};

`ifdef AXI_LINE_MEMORY_PROTOCOL_CHECK_EN
    logic aw_pend, ar_pend, err_q;

    // Sticky checker: wlast/wid consistency and valids withdrawn before their handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_pend <= 1'b0;
            ar_pend <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            aw_pend <= bus.awvalid & ~bus.awready;
            ar_pend <= bus.arvalid & ~bus.arready;
            if ((w_fire && ((bus.wlast != last_beat) || (bus.wid != awid_q))) ||
                (aw_pend && !bus.awvalid) || (ar_pend && !bus.arvalid))
                err_q <= 1'b1;
        end
    end

    assign protocol_err = err_q;
`else
    logic unused_w_bits;
    assign unused_w_bits = ^{bus.wlast, bus.wid};
    assign protocol_err  = 1'b0;
`endif
endmodule

// File: tb/tb_axi_line_memory.sv
// Directed self-checking bench for axi_line_memory (READ_LATENCY = 4).
module tb_axi_line_memory;
    localparam int LAT = 4;
`ifdef AXI_LINE_MEMORY_PROTOCOL_CHECK_EN
    localparam logic PCHK = 1'b1;
`else
    localparam logic PCHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic protocol_err;
    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [31:0] vbuf [16];

    always #5 clk = ~clk;

    axi_line_memory_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(4)) bus ();

    axi_line_memory #(
        .ADDR_WIDTH(26), .DATA_WIDTH(32), .MEM_WORDS_LOG2(12),
        .READ_LATENCY(LAT), .ID_WIDTH(4), .LEN_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .protocol_err(protocol_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [25:0] addr, input logic [3:0] len, input logic [3:0] id,
                               input int n, input int last_at);
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len; bus.awid = id;
        #1 chk("awready", bus.awready, 1);
        tick();
        bus.awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.wvalid = 1'b1; bus.wid = id; bus.wdata = vbuf[i]; bus.wlast = (i == last_at);
            #1 chk("wready", bus.wready, 1);
            chk("bvalid_early", bus.bvalid, 0);
            tick();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
        #1 chk("bvalid", bus.bvalid, 1);
        chk("bid", bus.bid, id);
        tick();
        bus.bready = 1'b0;
        #1 chk("bvalid_drop", bus.bvalid, 0);
    endtask

    task automatic read_burst(input logic [25:0] addr, input logic [3:0] len, input logic [3:0] id,
                              input int n, input int stall_at, input int stall_n);
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len; bus.arid = id;
        #1 chk("arready", bus.arready, 1);
        tick();
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            #1 chk("rvalid_latency", bus.rvalid, 0);
            tick();
        end
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                bus.rready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    #1 chk("stall_rvalid", bus.rvalid, 1);
                    chk("stall_rdata", bus.rdata, vbuf[i]);
                    tick();
                end
                bus.rready = 1'b1;
            end
            #1 chk("rvalid", bus.rvalid, 1);
            chk("rdata", bus.rdata, vbuf[i]);
            chk("rlast", bus.rlast, (i == n - 1));
            chk("rid", bus.rid, id);
            tick();
        end
        #1 chk("rvalid_drop", bus.rvalid, 0);
        bus.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.awvalid = 0; bus.awid = 0; bus.awlen = 0; bus.awaddr = 0;
        bus.wvalid = 0; bus.wid = 0; bus.wdata = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.arlen = 0; bus.araddr = 0; bus.rready = 0;
        tick();
        tick();
        chk("rst_awready", bus.awready, 0);
        chk("rst_arready", bus.arready, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_rid", bus.rid, 0);
        chk("rst_bid", bus.bid, 0);
        chk("rst_perr", protocol_err, 0);
        rst_n = 1'b1;
        #1 chk("idle_arready", bus.arready, 1);

        // four-beat flush then refill of the same line
        vbuf[0] = 32'h11; vbuf[1] = 32'h22; vbuf[2] = 32'h33; vbuf[3] = 32'h44;
        write_burst(26'h40, 4'd4, 4'd0, 4, 3);
        read_burst(26'h40, 4'd4, 4'd1, 4, -1, 0);
        read_burst(26'h40, 4'd4, 4'd1, 4, 1, 3);

        // simultaneous AW and AR: write wins, read sees the new data
        bus.awvalid = 1'b1; bus.awaddr = 26'h40; bus.awlen = 4'd1; bus.awid = 4'd2;
        bus.arvalid = 1'b1; bus.araddr = 26'h40; bus.arlen = 4'd1; bus.arid = 4'd3;
        #1 chk("prio_awready", bus.awready, 1);
        chk("prio_arready_idle", bus.arready, 0);
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wid = 4'd2; bus.wdata = 32'hAA; bus.wlast = 1'b1;
        #1 chk("prio_arready_wr", bus.arready, 0);
        tick();
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
        #1 chk("prio_bvalid", bus.bvalid, 1);
        chk("prio_arready_resp", bus.arready, 0);
        tick();
        bus.bready = 1'b0;
        vbuf[0] = 32'hAA;
        read_burst(26'h40, 4'd1, 4'd3, 1, -1, 0);

        // wrap-around at the top of memory
        vbuf[0] = 32'h5; vbuf[1] = 32'h6;
        write_burst(26'h3FFC, 4'd2, 4'd4, 2, 1);
        read_burst(26'h3FFC, 4'd2, 4'd5, 2, -1, 0);
        vbuf[0] = 32'h6;
        read_burst(26'h0, 4'd1, 4'd5, 1, -1, 0);

        // LEN of 0 behaves as a single beat
        vbuf[0] = 32'h77;
        write_burst(26'h80, 4'd0, 4'd6, 1, 0);
        read_burst(26'h80, 4'd0, 4'd7, 1, -1, 0);

        // early wlast: flagged only when the checker is built
        vbuf[0] = 32'h1; vbuf[1] = 32'h2;
        write_burst(26'h100, 4'd2, 4'd8, 2, 0);
        chk("perr_set", protocol_err, PCHK);
        tick();
        #1 chk("perr_hold", protocol_err, PCHK);

        // reset during the second read beat
        bus.arvalid = 1'b1; bus.araddr = 26'h40; bus.arlen = 4'd4; bus.arid = 4'd9;
        #1 chk("rr_arready", bus.arready, 1);
        tick();
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        repeat (LAT) tick();
        #1 chk("rr_beat0", bus.rdata, 32'hAA);
        tick();
        bus.rready = 1'b0; rst_n = 1'b0;
        #1 chk("rr_beat1_valid", bus.rvalid, 1);
        chk("rr_beat1_data", bus.rdata, 32'h22);
        tick();
        chk("rr_rvalid_drop", bus.rvalid, 0);
        chk("rr_rlast_drop", bus.rlast, 0);
        chk("rr_perr_clear", protocol_err, 0);
        chk("rr_arready_in_rst", bus.arready, 0);
        rst_n = 1'b1;
        #1 chk("rr_arready_after", bus.arready, 1);
        vbuf[0] = 32'hAA; vbuf[1] = 32'h22;
        read_burst(26'h40, 4'd2, 4'd1, 2, -1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
